// File: rtl/quad_decoder_pkg.sv
// quad_pkg: phase encoding, FSM state type and phase-order helpers for the quadrature decoder.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam int N_BITS_DEF = 3;

    typedef logic [0:0] state_t;
    localparam state_t UNPRIMED = 1'b0;
    localparam state_t TRACK    = 1'b1;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] phase_next(input logic [1:0] p);
        return p == PH_00 ? PH_01 : p == PH_01 ? PH_11 : p == PH_11 ? PH_10 : PH_00;
    endfunction

    function automatic logic [1:0] phase_prev(input logic [1:0] p);
        return p == PH_00 ? PH_10 : p == PH_10 ? PH_11 : p == PH_11 ? PH_01 : PH_00;
    endfunction

endpackage

// File: rtl/quad_decoder_sync_ff.sv
// sync_ff: multi-flop synchronizer for one asynchronous input bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r <= '0;
        else          r <= {r[STAGES-2:0], d};
    end

    assign q = r[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: synchronizes A/B quadrature inputs, emits step/up pulses,
// tracks a wrapping position count and flags illegal double-bit transitions.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int N_BITS      = N_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              a_in,
    input  logic              b_in,
    input  logic              clear,
    output logic              step,
    output logic              up,
    output logic [N_BITS-1:0] count,
    output logic              err
);

    logic       a_sync, b_sync;
    logic [1:0] phase, prev_phase;
    state_t     state;
    logic       fwd, bwd, bad;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .n_reset(n_reset), .d(a_in), .q(a_sync));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .n_reset(n_reset), .d(b_in), .q(b_sync));

    assign phase = {a_sync, b_sync};

    always_comb begin
        fwd = state == TRACK && phase == phase_next(prev_phase);
        bwd = state == TRACK && phase == phase_prev(prev_phase);
        bad = state == TRACK && (phase ^ prev_phase) == 2'b11;
    end

    // prev_phase always follows phase: UNPRIMED primes it, TRACK resyncs even after an illegal jump.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= UNPRIMED;
            prev_phase <= PH_00;
            step       <= 1'b0;
            up         <= 1'b0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            state      <= TRACK;
            prev_phase <= phase;
            step       <= fwd | bwd;
            if (fwd | bwd) up <= fwd;
            count      <= clear ? '0 : fwd ? count + N_BITS'(1) : bwd ? count - N_BITS'(1) : count;
            err        <= clear ? 1'b0 : err | bad;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: scoreboard bench; expected step events are queued when inputs change
// and compared when the monitor reaches their due cycle.
module tb_quad_decoder;

    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          n_reset = 1'b1;
    logic          a_in = 1'b0;
    logic          b_in = 1'b0;
    logic          clear = 1'b0;
    logic          step, up, err;
    logic [NB-1:0] count;

    quad_decoder #(.N_BITS(NB), .SYNC_STAGES(2)) dut (
        .clk(clk), .n_reset(n_reset), .a_in(a_in), .b_in(b_in), .clear(clear),
        .step(step), .up(up), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic          step;
        logic          up;
        logic [NB-1:0] count;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;
    logic [1:0]    last_ph = 2'b00;
    logic          m_up = 1'b0;
    logic [NB-1:0] m_cnt = '0;
    logic          m_err = 1'b0;
    logic [1:0]    seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int idx(input logic [1:0] p);
        for (int i = 0; i < 4; i++) if (seq[i] == p) return i;
        return 0;
    endfunction

    // Reference: classify the new phase by its distance along the forward sequence.
    task automatic predict(input logic [1:0] ph);
        int d;
        d = (idx(ph) - idx(last_ph) + 4) % 4;
        if (d == 1) begin
            m_cnt = m_cnt + 1'b1;
            m_up  = 1'b1;
        end else if (d == 3) begin
            m_cnt = m_cnt - 1'b1;
            m_up  = 1'b0;
        end else if (d == 2) begin
            m_err = 1'b1;
        end
        if (d != 0) sb.push_back('{cyc + 3, d != 2, m_up, m_cnt, m_err});
        last_ph = ph;
    endtask

    task automatic drive(input logic [1:0] ph, input int hold);
        @(negedge clk);
        {a_in, b_in} = ph;
        predict(ph);
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_cnt = '0;
        m_err = 1'b0;
        check("clear_count", count, 0);
        check("clear_err", err, 0);
    endtask

    task automatic reset_on();
        @(negedge clk);
        n_reset = 1'b0;
        mon_en  = 1'b0;
        sb.delete();
        m_cnt = '0;
        m_up  = 1'b0;
        m_err = 1'b0;
        #1;
        check("rst_step", step, 0);
        check("rst_up", up, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
    endtask

    // After release the synchronizers restart from 00, so the held pins look like a change from 00.
    task automatic reset_off(input int hold);
        repeat (hold) @(negedge clk);
        n_reset = 1'b1;
        last_ph = 2'b00;
        mon_en  = 1'b1;
        predict({a_in, b_in});
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("step", step, e.step);
                check("up", up, e.up);
                check("count", count, e.count);
                check("err", err, e.err);
            end else begin
                check("idle_step", step, 0);
            end
        end
    end

    initial begin
        reset_on();
        reset_off(3);
        repeat (10) @(negedge clk);
        check("idle_count", count, 0);
        check("idle_err", err, 0);

        for (int r = 0; r < 3; r++) begin
            drive(2'b01, 8);
            drive(2'b11, 8);
            drive(2'b10, 8);
            drive(2'b00, 8);
        end
        repeat (4) @(negedge clk);
        check("fwd_final_count", count, 4);
        check("fwd_final_up", up, 1);

        do_clear();
        drive(2'b10, 8);
        drive(2'b11, 8);
        check("rev_count", count, 6);
        check("rev_up", up, 0);

        drive(2'b01, 8);
        drive(2'b00, 8);
        drive(2'b11, 8);
        check("illegal_err", err, 1);
        check("illegal_count", count, 4);
        check("illegal_step", step, 0);
        do_clear();

        reset_on();
        {a_in, b_in} = 2'b11;
        reset_off(3);
        repeat (10) @(negedge clk);
        drive(2'b10, 8);
        check("post_rst_count", count, 1);
        check("post_rst_up", up, 1);

        drive(2'b00, 0);
        reset_on();
        reset_off(3);
        repeat (10) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter N_BITS, default 3: width of position count, which matches the up/down counter's count width.
REQ-002 Parameter SYNC_STAGES, default 2: flop stages on each quadrature input (minimum 2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 a_in  input  1  quadrature channel A, asynchronous to clk.
REQ-006 b_in  input  1  quadrature channel B, asynchronous to clk.
REQ-007 clear  input  1  synchronous clear of count and err.
REQ-008 step  output  1  one-cycle pulse per legal quadrature transition; drives a counter enable.
REQ-009 up  output  1  direction of most recent legal step (1 = up); drives a counter's up input.
REQ-010 count  output  N_BITS  internal position, wraps modulo 2^N_BITS.
REQ-011 err  output  1  sticky flag for an illegal (double-bit) transition.

Function
REQ-012 a_in and b_in SHALL each pass through a SYNC_STAGES flop synchronizer before any use.
REQ-013 Phase code SHALL be {a_sync,b_sync}; forward sequence 00->01->11->10->00.
REQ-014 FSM states SHALL be UNPRIMED and TRACK.
REQ-015 UNPRIMED: the first clock after reset release loads prev_phase from the synchronized phase, with no step and no count change, then goes to TRACK.
REQ-016 TRACK, phase == prev_phase: no step, no change.
REQ-017 TRACK, phase is the forward successor: step=1, up=1, count+1, prev_phase updated.
REQ-018 TRACK, phase is the forward predecessor: step=1, up=0, count-1, prev_phase updated.
REQ-019 TRACK, both bits changed: step=0, count and up held, err set to 1, prev_phase updated to the new phase.
REQ-020 step, up, count and err SHALL be registered and SHALL update in the same cycle.
REQ-021 Latency: an input edge stable before clk edge k SHALL produce step in the cycle after edge k+SYNC_STAGES. That is 3 cycles at the default.
REQ-022 Wrap-around: count 2^N_BITS-1 up goes to 0; count 0 down goes to 2^N_BITS-1. No saturation and no flag.
REQ-023 clear=1: count<=0 and err<=0 next edge.
REQ-024 clear coincident with a legal step: count<=0, step still pulses, and up still updates.
REQ-025 clear coincident with an illegal transition: err<=0, because clear wins.
REQ-026 up SHALL hold its value between steps and SHALL NOT be affected by clear.

Reset
REQ-027 n_reset low SHALL asynchronously force:
- step=0, up=0, count=0, err=0
- FSM=UNPRIMED
- prev_phase=00
- all synchronizer flops=0
REQ-028 Reset deassertion is assumed synchronous to clk externally. Reset mid-step SHALL discard any in-flight transition; no step pulse follows reset release.

Structure
REQ-029 Package quad_pkg SHALL hold the phase encoding constants (PH_00, PH_01, PH_11, PH_10), the FSM state typedef and the default N_BITS.
REQ-030 Synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, async active-low reset), instantiated once per channel.
REQ-031 Expected RTL size: 120-300 lines including sync_ff.

Verification
REQ-032 Reset, then hold a=0,b=0 for 10 cycles -> step never asserted, count=0, err=0.
REQ-033 Forward sequence 01,11,10,00 repeated 3 times, 8 cycles per phase, N_BITS=3 -> 12 step pulses, up=1, count 0->1->...->7->0->...->4 final; each pulse 3 cycles after its input change.
REQ-034 From count=0, reverse sequence 10,11 -> count 7 then 6, up=0, two single-cycle step pulses.
REQ-035 From phase 00, jump to 11 -> err=1 within 3 cycles, no step, count unchanged. Then apply clear for 1 cycle -> err=0, count=0.
REQ-036 Drive a_in=1,b_in=1 during reset; release reset -> no step pulse, FSM reaches TRACK. Next legal change 11->10 -> one step with up=1.
REQ-037 Assert n_reset low 1 cycle after an input edge, mid-synchronizer -> outputs 0 immediately (asynchronously), and no step pulse after release.
